// File: rtl/freelist_rebuild_ctrl_pkg.sv
// Shared defaults for the free-list rebuild controller.
//   FL_N        : default number of push lanes per cycle
//   FL_PR_COUNT : default number of physical tags
//   fl_start()  : first tag the scan looks at (1 when tag 0 is reserved)
package freelist_rebuild_ctrl_pkg;
  localparam int FL_N        = 3;
  localparam int FL_PR_COUNT = 64;

  function automatic int fl_start(input logic exclude_zero);
    return exclude_zero ? 1 : 0;
  endfunction
endpackage

// File: rtl/freelist_rebuild_ctrl_pack.sv
// Combinational window compactor for the free-list rebuild scan.
//   base     : tag number of lane-0 of the window
//   used     : per-window-slot "do not push" bit (held by arch map or out of range)
//   push_en  : packed toward lane 0, one bit per pushed tag
//   push_tag : pushed tags in ascending order, 0 in unused lanes
//   k        : number of tags pushed this window
module freelist_rebuild_pack #(
  parameter int N     = 3,
  parameter int TAG_W = 6,
  parameter int PTR_W = 8,
  parameter int KW    = 2
) (
  input  logic [PTR_W-1:0]          base,
  input  logic [N-1:0]              used,
  output logic [N-1:0]              push_en,
  output logic [N-1:0][TAG_W-1:0]   push_tag,
  output logic [KW-1:0]             k
);
  // k doubles as the running output lane index while walking the window,
  // so free slots land in lanes 0..k-1 in ascending tag order.
  always_comb begin
    push_en  = '0;
    push_tag = '0;
    k        = '0;
    for (int i = 0; i < N; i++) begin
      if (!used[i]) begin
        push_en[k]  = 1'b1;
        push_tag[k] = TAG_W'(base + PTR_W'(i));
        k           = k + KW'(1);
      end
    end
  end
endmodule

// File: rtl/freelist_rebuild_ctrl.sv
// Free-list rebuild controller. On a recovery request it snapshots the
// architectural-map bitmap, flushes the free list for one cycle, then walks
// all tags N at a time pushing every tag not held by the snapshot.
//   clock, reset_n : rising-edge clock, async active-low reset
//   recover_req    : restart a rebuild (accepted in any state)
//   arch_used      : tag bitmap sampled only when recover_req is accepted
//   fl_flush       : one-cycle pulse emptying the free list
//   push_en/tag    : per-lane pushes, packed toward lane 0
//   busy           : high in FLUSH and SCAN
//   done           : one-cycle completion pulse
//   free_count     : tags pushed by the current or last rebuild
module freelist_rebuild_ctrl
  import freelist_rebuild_ctrl_pkg::*;
#(
  parameter int   N            = FL_N,
  parameter int   PR_COUNT     = FL_PR_COUNT,
  parameter logic EXCLUDE_ZERO = 1'b1
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  recover_req,
  input  logic [PR_COUNT-1:0]                   arch_used,
  output logic                                  fl_flush,
  output logic [N-1:0]                          push_en,
  output logic [N-1:0][$clog2(PR_COUNT)-1:0]    push_tag,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(PR_COUNT+1)-1:0]         free_count
);
  localparam int TAG_W = $clog2(PR_COUNT);
  localparam int PTR_W = $clog2(PR_COUNT + N) + 1;
  localparam int KW    = $clog2(N + 1);
  localparam int CNT_W = $clog2(PR_COUNT + 1);
  localparam logic [PTR_W-1:0] START = PTR_W'(fl_start(EXCLUDE_ZERO));

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SCAN, S_DONE} state_t;

  state_t                 state;
  logic [PR_COUNT-1:0]    snap;
  logic [PTR_W-1:0]       ptr;       // base of the next window to be registered
  logic                   last_win;  // window now on the outputs is the final one

  logic [N-1:0]             win_used;
  logic [N-1:0]             pk_en;
  logic [N-1:0][TAG_W-1:0]  pk_tag;
  logic [KW-1:0]            pk_k;

  // Tags past the end of the tag space look "used" so they are never pushed.
  for (genvar i = 0; i < N; i++) begin : g_win
    logic [PTR_W-1:0] idx;
    assign idx         = ptr + PTR_W'(i);
    assign win_used[i] = (idx >= PTR_W'(PR_COUNT)) ? 1'b1 : snap[idx[TAG_W-1:0]];
  end

  freelist_rebuild_pack #(
    .N     (N),
    .TAG_W (TAG_W),
    .PTR_W (PTR_W),
    .KW    (KW)
  ) u_pack (
    .base     (ptr),
    .used     (win_used),
    .push_en  (pk_en),
    .push_tag (pk_tag),
    .k        (pk_k)
  );

  // Outputs are registered together with the state: the window pushed in a
  // SCAN cycle was compacted during the previous cycle from ptr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      snap       <= '0;
      ptr        <= START;
      last_win   <= 1'b0;
      free_count <= '0;
      fl_flush   <= 1'b0;
      push_en    <= '0;
      push_tag   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fl_flush <= 1'b0;
      done     <= 1'b0;
      if (recover_req) begin
        // Accepted in every state; restarting discards any rebuild in flight.
        state      <= S_FLUSH;
        snap       <= arch_used;
        ptr        <= START;
        last_win   <= 1'b0;
        free_count <= '0;
        fl_flush   <= 1'b1;
        busy       <= 1'b1;
        push_en    <= '0;
        push_tag   <= '0;
      end else begin
        case (state)
          S_IDLE: ;
          S_FLUSH, S_SCAN: begin
            if (state == S_SCAN && last_win) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              push_en  <= '0;
              push_tag <= '0;
            end else begin
              state      <= S_SCAN;
              push_en    <= pk_en;
              push_tag   <= pk_tag;
              free_count <= free_count + CNT_W'(pk_k);
              ptr        <= ptr + PTR_W'(N);
              last_win   <= (ptr + PTR_W'(N)) >= PTR_W'(PR_COUNT);
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
